// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response bundle between the two ALU issue paths and the shared adder
interface adder_arbiter_if #(parameter int W = 32);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_s;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_s;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic [3:0]   rsp_flags;
  logic [3:0]   flags;
  logic         grant_last;

  modport master (
    output req0_valid, req0_a, req0_b, req0_s,
    output req1_valid, req1_a, req1_b, req1_s,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_flags, flags, grant_last
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_s,
    input  req1_valid, req1_a, req1_b, req1_s,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_flags, flags, grant_last
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one 32-bit adder with a registered, id-tagged response
module adder_arbiter #(
  parameter int W = 32
) (
  input logic           clk,
  input logic           rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state;
  state_t       next_state;
  logic         can_accept;
  logic         winner;
  logic         accept;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_s;
  logic [W:0]   sum33;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;
  logic         rsp_id_q;
  logic [W-1:0] rsp_sum_q;
  logic [3:0]   rsp_flags_q;
  logic [3:0]   flags_q;
  logic         grant_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Grant depends only on valids, rsp_ready and state, never on operands.
  always_comb begin
    next_state      = state;
    can_accept      = (state == EMPTY) || bus.rsp_ready;
    winner          = 1'b0;
    accept          = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = ~grant_last_q;
    end else begin
      winner = bus.req1_valid;
    end
    accept         = can_accept && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept && !winner;
    bus.req1_ready = accept && winner;
    case (state)
      EMPTY:   if (accept) next_state = FULL;
      FULL:    if (bus.rsp_ready && !accept) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  // N is the sign of the infinite-precision sum, so it flips when V is set.
  always_comb begin
    op_a   = winner ? bus.req1_a : bus.req0_a;
    op_b   = winner ? bus.req1_b : bus.req0_b;
    op_s   = winner ? bus.req1_s : bus.req0_s;
    sum33  = {1'b0, op_a} + {1'b0, op_b};
    flag_v = (op_a[W-1] == op_b[W-1]) && (sum33[W-1] != op_a[W-1]);
    flag_n = flag_v ? op_a[W-1] : sum33[W-1];
    flag_z = (sum33 == '0);
    flag_c = sum33[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_flags_q  <= 4'b0000;
      flags_q      <= 4'b0000;
      grant_last_q <= 1'b1;
    end else if (accept) begin
      rsp_id_q     <= winner;
      rsp_sum_q    <= sum33[W-1:0];
      rsp_flags_q  <= {flag_n, flag_z, flag_c, flag_v};
      grant_last_q <= winner;
      if (op_s) begin
        flags_q <= {flag_n, flag_z, flag_c, flag_v};
      end
    end
  end

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.flags      = flags_q;
  assign bus.grant_last = grant_last_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench: directed cases then randomized traffic against a reference model
module tb_adder_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adder_arbiter_if #(.W(32)) bus ();

  adder_arbiter #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic [3:0]  rf;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx = 0;
  int   checks = 0;
  int   errors = 0;

  logic       m_full  = 1'b0;
  logic [3:0] m_flags = 4'b0000;
  logic       m_glast = 1'b1;
  logic       acc0    = 1'b0;
  logic       acc1    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Flags from true signed/unsigned 64-bit arithmetic.
  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, us, ss;
    logic n, z, c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    us = ua + ub;
    ss = sa + sb;
    n  = (ss < 0);
    z  = (us == 0);
    c  = (us >= 64'h1_0000_0000);
    v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference model: predicts readies and arch state, queues each accepted result.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full  = 1'b0;
      m_flags = 4'b0000;
      m_glast = 1'b1;
      acc0    = 1'b0;
      acc1    = 1'b0;
    end else begin
      logic       ca, w, acc, s;
      logic [31:0] a, b;
      exp_t       e;
      ca = !m_full || bus.rsp_ready;
      if (bus.req0_valid && bus.req1_valid) w = !m_glast;
      else w = bus.req1_valid;
      acc = ca && (bus.req0_valid || bus.req1_valid);
      chk("req0_ready", bus.req0_ready, acc && !w);
      chk("req1_ready", bus.req1_ready, acc && w);
      chk("rsp_valid", bus.rsp_valid, m_full);
      chk("flags", bus.flags, m_flags);
      chk("grant_last", bus.grant_last, m_glast);
      acc0 = acc && !w;
      acc1 = acc && w;
      if (acc) begin
        a     = w ? bus.req1_a : bus.req0_a;
        b     = w ? bus.req1_b : bus.req0_b;
        s     = w ? bus.req1_s : bus.req0_s;
        e.id  = w;
        e.sum = a + b;
        e.rf  = ref_flags(a, b);
        exp_q.push_back(e);
        if (s) m_flags = e.rf;
        m_glast = w;
        m_full  = 1'b1;
      end else if (m_full && bus.rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: held response must match the oldest undelivered expectation.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx = exp_q.size();
    end else if (bus.rsp_valid) begin
      if (rd_idx >= exp_q.size()) begin
        checks++;
        errors++;
        $display("FAIL rsp_spurious: got rsp_valid=1 expected no pending result at %0t", $time);
      end else begin
        chk("rsp_id", bus.rsp_id, exp_q[rd_idx].id);
        chk("rsp_sum", bus.rsp_sum, exp_q[rd_idx].sum);
        chk("rsp_flags", bus.rsp_flags, exp_q[rd_idx].rf);
        if (bus.rsp_ready) rd_idx++;
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b, input bit s);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_s = s;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_s = s;
    end
  endtask

  task automatic op(input bit id, input logic [31:0] a, input logic [31:0] b, input bit s,
                    input logic [31:0] esum, input logic [3:0] erf, input logic [3:0] efl);
    set_req(id, 1'b1, a, b, s);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("op_ready", id ? bus.req1_ready : bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("op_rsp_valid", bus.rsp_valid, 1'b1);
    chk("op_rsp_id", bus.rsp_id, id);
    chk("op_rsp_sum", bus.rsp_sum, esum);
    chk("op_rsp_flags", bus.rsp_flags, erf);
    chk("op_flags", bus.flags, efl);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_rsp_sum", bus.rsp_sum, 32'h0);
    chk("rst_rsp_flags", bus.rsp_flags, 4'b0000);
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_grant_last", bus.grant_last, 1'b1);
    rst_n = 1'b1;

    op(1'b0, 32'd5, 32'd7, 1'b1, 32'd12, 4'b0000, 4'b0000);
    op(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b0001, 4'b0001);
    op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 4'b1011, 4'b0001);
    op(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0100, 4'b0100);
    op(1'b1, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'b0010, 4'b0010);

    // Alternation: grant_last is 1 here, so 0 wins first.
    set_req(1'b0, 1'b1, pick(), pick(), $urandom % 2);
    set_req(1'b1, 1'b1, pick(), pick(), $urandom % 2);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("alt_r0", bus.req0_ready, (i % 2) == 0);
        chk("alt_r1", bus.req1_ready, (i % 2) == 1);
      end
      if (i > 0) chk("alt_id", bus.rsp_id, (i - 1) % 2);
      @(posedge clk); #1;
      if (i == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else if (i < 3) begin
        set_req(i % 2, 1'b1, pick(), pick(), $urandom % 2);
      end
    end

    // Backpressure with both requesters pending.
    set_req(1'b0, 1'b1, pick(), pick(), $urandom % 2);
    set_req(1'b1, 1'b1, pick(), pick(), $urandom % 2);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_r0", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, pick(), pick(), $urandom % 2);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_r0", bus.req0_ready, 1'b0);
      chk("bp_r1", bus.req1_ready, 1'b0);
      chk("bp_id", bus.rsp_id, 1'b0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_r1", bus.req1_ready, 1'b1);
    chk("bp_release_r0", bus.req0_ready, 1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_id", bus.rsp_id, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset while a response is held.
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    chk("mid_accept", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_flags_set", bus.flags, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_flags", bus.flags, 4'b0000);
    chk("mid_grant_last", bus.grant_last, 1'b1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, pick(), pick(), $urandom % 2);
    set_req(1'b1, 1'b1, pick(), pick(), $urandom % 2);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("mid_tie_r0", bus.req0_ready, 1'b1);
    chk("mid_tie_r1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Randomized traffic; operands only change once accepted or idle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (acc0 || !bus.req0_valid)
        set_req(1'b0, ($urandom % 4) != 0, pick(), pick(), $urandom % 2);
      if (acc1 || !bus.req1_valid)
        set_req(1'b1, ($urandom % 4) != 0, pick(), pick(), $urandom % 2);
      bus.rsp_ready = ($urandom % 4) != 0;
    end

    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", exp_q.size() - rd_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
